// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 scancode decoder: FSM states, prefix/status bytes, event layout.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0,
    ST_PAUSE
  } state_e;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_FA = 8'hFA;
  localparam logic [7:0] SC_FE = 8'hFE;
  localparam logic [7:0] SC_FC = 8'hFC;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;

  localparam int         EVT_W      = 10;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } evt_t;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FA) || (b == SC_FE) || (b == SC_FC);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / event-out bundle of the scancode decoder; master = surrounding system, slave = decoder.
interface ps2_scancode_decoder_if;
  logic [7:0]               rx_data;
  logic                     rx_stb;
  logic                     rx_enable;
  logic [ps2_pkg::EVT_W-1:0] evt_data;
  logic                     evt_valid;
  logic                     evt_ready;
  logic                     err_stb;
  logic                     ovf_stb;

  modport master (
    output rx_data, rx_stb, evt_ready,
    input  rx_enable, evt_data, evt_valid, err_stb, ovf_stb
  );

  modport slave (
    input  rx_data, rx_stb, evt_ready,
    output rx_enable, evt_data, evt_valid, err_stb, ovf_stb
  );
endinterface

// File: rtl/ps2_event_fifo.sv
// Event FIFO: power-of-two depth, full-and-pop accepts a push, empty never passes data through.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_full, w_pop, w_wr;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);
  assign w_wr   = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_ovf <= i_push && !w_wr;
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_ovf   = r_ovf;
endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, pause skipper, inter-byte timeout.
// Define PS2_DECODER_FIFO_EN to buffer events in a FIFO with rx_enable/ovf_stb flow control.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input logic                   clk,
  input logic                   rst,
  ps2_scancode_decoder_if.slave bus
);
  state_e      r_state, w_next, w_eff;
  logic [2:0]  r_skip, w_skip_next;
  logic [19:0] r_timer;
  logic        r_err;
  logic        w_stb, w_reproc, w_expire, w_push, w_err;
  logic [7:0]  w_byte;
  evt_t        w_evt;

  assign w_stb  = bus.rx_stb;
  assign w_byte = bus.rx_data;

  // A prefix byte arriving mid-sequence aborts it and starts over as a fresh byte.
  assign w_reproc = w_stb &&
    (((r_state inside {ST_GOT_E0, ST_GOT_F0, ST_GOT_E0F0}) && (w_byte == SC_E0 || w_byte == SC_E1)) ||
     ((r_state inside {ST_GOT_F0, ST_GOT_E0F0}) && (w_byte == SC_F0)));
  assign w_eff    = w_reproc ? ST_IDLE : r_state;
  assign w_expire = !w_stb && (r_timer == 20'd1) && (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_skip  <= w_skip_next;
      r_timer <= w_stb ? TIMEOUT_CYCLES : ((r_timer != '0) ? r_timer - 20'd1 : r_timer);
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_skip_next = r_skip;
    if (w_stb) begin
      case (w_eff)
        ST_IDLE: begin
          if (w_byte == SC_E0)      w_next = ST_GOT_E0;
          else if (w_byte == SC_F0) w_next = ST_GOT_F0;
          else if (w_byte == SC_E1) begin
            w_next      = ST_PAUSE;
            w_skip_next = PAUSE_SKIP;
          end else                  w_next = ST_IDLE;
        end
        ST_GOT_E0: w_next = (w_byte == SC_F0) ? ST_GOT_E0F0 : ST_IDLE;
        ST_PAUSE: begin
          w_skip_next = r_skip - 3'd1;
          if (r_skip == 3'd1) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end else if (w_expire) begin
      w_next = ST_IDLE;
    end
  end

  always_comb begin
    w_push = 1'b0;
    w_evt  = '0;
    w_err  = w_reproc;
    if (w_stb) begin
      case (w_eff)
        ST_IDLE: begin
          if (w_byte == SC_00 || w_byte == SC_FF) w_err = 1'b1;
          else if (!(w_byte inside {SC_E0, SC_F0, SC_E1}) && !is_status(w_byte)) begin
            w_push = 1'b1;
            w_evt  = '{ext: 1'b0, rel: 1'b0, code: w_byte};
          end
        end
        ST_GOT_E0: begin
          w_push = (w_byte != SC_F0);
          w_evt  = '{ext: 1'b1, rel: 1'b0, code: w_byte};
        end
        ST_GOT_F0: begin
          w_push = 1'b1;
          w_evt  = '{ext: 1'b0, rel: 1'b1, code: w_byte};
        end
        ST_GOT_E0F0: begin
          w_push = 1'b1;
          w_evt  = '{ext: 1'b1, rel: 1'b1, code: w_byte};
        end
        ST_PAUSE: begin
          w_push = (r_skip == 3'd1);
          w_evt  = '{ext: 1'b0, rel: 1'b0, code: SC_E1};
        end
        default: ;
      endcase
    end
  end

  assign bus.err_stb = r_err;

`ifdef PS2_DECODER_FIFO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic          w_valid;
  logic [CW-1:0] w_count;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (w_valid && bus.evt_ready),
    .o_data  (bus.evt_data),
    .o_valid (w_valid),
    .o_count (w_count),
    .o_ovf   (bus.ovf_stb)
  );

  assign bus.evt_valid = w_valid;
  assign bus.rx_enable = (w_count < CW'(FIFO_DEPTH - 1));
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic             r_evt_valid;
  logic [EVT_W-1:0] r_evt_data;
  logic             w_unused_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_data  <= '0;
    end else begin
      r_evt_valid <= w_push;
      if (w_push) r_evt_data <= w_evt;
    end
  end

  assign w_unused_ready = bus.evt_ready;
  assign bus.evt_valid  = r_evt_valid;
  assign bus.evt_data   = r_evt_data;
  assign bus.rx_enable  = 1'b1;
  assign bus.ovf_stb    = 1'b0;
`endif
endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20'd1000000: clk cycles allowed between bytes of one multi-byte sequence.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port rx_data, input, 8: received scancode byte from the PS/2 receiver.
REQ-006 SHALL have port rx_stb, input, 1: one-cycle strobe; rx_data is valid in that cycle.
REQ-007 SHALL have port rx_enable, output, 1: receive permission back to the PS/2 receiver.
REQ-008 SHALL have port evt_data, output, 10: event word {extended, release, code[7:0]}.
REQ-009 SHALL have port evt_valid, output, 1: evt_data is valid.
REQ-010 SHALL have port evt_ready, input, 1: consumer pops or accepts the event.
REQ-011 SHALL have port err_stb, output, 1: one-cycle pulse on a protocol or status error.
REQ-012 SHALL have port ovf_stb, output, 1: one-cycle pulse when an event is dropped because the FIFO is full.

Function
REQ-013 SHALL implement states IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE.
REQ-014 In IDLE, byte E0 -> GOT_E0, F0 -> GOT_F0, E1 -> PAUSE with skip counter = 7.
REQ-015 In IDLE, bytes 00, FF, AA, FA, FE and FC SHALL emit no event; 00 and FF also pulse err_stb.
REQ-016 In GOT_E0, byte F0 -> GOT_E0F0.
REQ-017 Any other byte SHALL emit an event {ext, rel, byte} and return to IDLE: ext=1 from GOT_E0 or GOT_E0F0; rel=1 from GOT_F0 or GOT_E0F0.
REQ-018 Byte E0 or E1 in a non-IDLE, non-PAUSE state, or F0 in GOT_F0 or GOT_E0F0, SHALL pulse err_stb and be reprocessed as if received in IDLE.
REQ-019 In PAUSE, each byte SHALL decrement the skip counter; when the counter reaches 0, the block SHALL emit event {0,0,E1} and return to IDLE.
REQ-020 Inter-byte timer: reloaded on each rx_stb; in any non-IDLE state, expiry SHALL return to IDLE silently with no event and no err_stb.
REQ-021 Latency: an event completed by rx_stb in cycle N SHALL be visible with evt_valid=1 in cycle N+1.
REQ-022 The FIFO SHALL be first-in first-out; evt_valid = not empty; evt_data = head entry; a pop occurs when evt_valid and evt_ready are both 1.
REQ-023 A push when full SHALL drop the new event and pulse ovf_stb; existing entries SHALL be unchanged.
REQ-024 A simultaneous push and pop when full SHALL accept both with no ovf_stb; a simultaneous push and pop when empty SHALL not pass the new event through in the same cycle.
REQ-025 rx_enable SHALL be 0 when the FIFO occupancy is at least FIFO_DEPTH-1, and 1 otherwise.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use a counter of width log2(FIFO_DEPTH)+1 bits.
REQ-027 rx_stb in the same cycle as timer expiry SHALL take priority: the byte is processed and the timer reloaded.

Reset
REQ-028 While rst=1: state=IDLE, FIFO empty, timer and skip counter cleared, evt_valid=0, err_stb=0, ovf_stb=0, rx_enable=1.
REQ-029 Assertion of rst mid-sequence SHALL discard the partial prefix; the first byte after release SHALL be decoded from IDLE.

Configuration
REQ-030 With macro PS2_DECODER_FIFO_EN defined, the FIFO, ovf_stb and rx_enable flow control SHALL exist as specified above.
REQ-031 Without PS2_DECODER_FIFO_EN: evt_valid SHALL be a registered one-cycle strobe with the same N+1 latency; evt_ready is ignored; rx_enable=1 constantly; ovf_stb=0 constantly.

Structure
REQ-032 Package ps2_pkg SHALL hold the state encoding, prefix and status byte constants (E0, F0, E1, AA, FA, FE, FC, 00, FF), the event word width (10) and the pause skip count (7).
REQ-033 The FIFO SHALL be a sub-module ps2_event_fifo, parameterised by depth and width, instantiated only under PS2_DECODER_FIFO_EN.

Verification
REQ-034 Byte 1C -> in the next cycle evt_valid=1, evt_data=0_0_1C.
REQ-035 Bytes E0, F0, 75 -> exactly one event 1_1_75; E0, 75 -> 1_0_75.
REQ-036 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event 0_0_E1; no err_stb.
REQ-037 Eight events with evt_ready=0 -> rx_enable=0 after the seventh; the ninth event -> ovf_stb pulse; pops return the first eight events in order.
REQ-038 Byte E0, then TIMEOUT_CYCLES of idle, then byte 1C -> event 0_0_1C; no err_stb.
REQ-039 Byte F0, rst pulse, then byte 1C -> event 0_0_1C; F0 F0 -> err_stb pulse followed by state GOT_F0.
